command_stream_generator: RTL and testbench
===========================================

COMMAND_STREAM_GENERATOR -- requirements
Module: command_stream_generator

Interface
REQ-001 SHALL have parameter CMD_STREAM_WIDTH, default 32, the command stream data width in bits; legal values 32 and 64.
REQ-002 SHALL have port aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have ports s_req_valid (input, 1), s_req_ready (output, 1), s_req_op (input, 4), s_req_imm (input, 28) and s_req_len (input, 14), forming the command request channel.
REQ-005 SHALL have ports s_payload_axis_tvalid (input, 1), s_payload_axis_tready (output, 1), s_payload_axis_tlast (input, 1) and s_payload_axis_tdata (input, CMD_STREAM_WIDTH), forming the payload source.
REQ-006 SHALL have ports m_cmd_axis_tvalid (output, 1), m_cmd_axis_tready (input, 1), m_cmd_axis_tlast (output, 1) and m_cmd_axis_tdata (output, CMD_STREAM_WIDTH), forming the command stream toward the parser.
REQ-007 SHALL have ports busy (output, 1), high when the module is not IDLE, and dbgState (output, 3), the current state encoding.

Function
REQ-008 SHALL use this header word: opcode in bits [31:28], immediate in bits [27:0], and zeros in all bits above 31.
REQ-009 SHALL decode opcodes as NOP=0, RENDER_CONFIG=1, FRAMEBUFFER=2, TRIANGLE_STREAM=3, TEXTURE_STREAM=4 and FOG_LUT_STREAM=5; opcodes 6-15 SHALL be sent as NOP with immediate 0.
REQ-010 SHALL set the payload beat count per opcode: NOP 0; FRAMEBUFFER 0; RENDER_CONFIG 1; FOG_LUT_STREAM 33; TRIANGLE_STREAM and TEXTURE_STREAM take s_req_len.
REQ-011 SHALL use the state machine IDLE -> HEADER -> PAYLOAD -> IDLE; HEADER SHALL return directly to IDLE when the beat count is 0.
REQ-012 SHALL, in IDLE, hold s_req_ready=1 and, on s_req_valid, capture op, imm and beat count and go to HEADER, one accepted request per handshake.
REQ-013 SHALL, in HEADER, drive m_cmd_axis_tvalid=1 with the header word, and SHALL set tlast=1 only when the beat count is 0.
REQ-014 SHALL, in PAYLOAD, pass beats straight through with s_payload_axis_tready = m_cmd_axis_tready, and decrement the counter on each output handshake.
REQ-015 SHALL assert m_cmd_axis_tlast on the beat where the counter equals 1, and SHALL go to IDLE after that beat.
REQ-016 SHALL hold m_cmd_axis_tdata and m_cmd_axis_tlast stable while tvalid=1 and tready=0, per AXI-Stream.
REQ-017 SHALL keep s_payload_axis_tready=0 in IDLE and HEADER; the payload source is never consumed outside PAYLOAD.
REQ-018 SHALL give a latency of 1 cycle from request handshake to the header being valid.
REQ-019 SHALL sustain full throughput (1 beat/cycle) in PAYLOAD when the payload source is valid and the output is ready.
REQ-020 SHALL treat s_req_len=0 for TRIANGLE_STREAM or TEXTURE_STREAM as a header-only command.

Reset
REQ-021 SHALL, while resetn=0, hold state=IDLE, s_req_ready=0, m_cmd_axis_tvalid=0, m_cmd_axis_tlast=0, s_payload_axis_tready=0, busy=0 and the counter at 0; m_cmd_axis_tdata SHALL be 0.
REQ-022 SHALL set s_req_ready=1 on the first clock edge after resetn deasserts.
REQ-023 SHALL abandon any command in progress when reset asserts mid-command, with no partial tlast emitted.

Configuration
REQ-024 SHALL, when macro CMD_GEN_TLAST_CHECK_EN is defined, add output tlastError (1 bit, reset 0), set sticky on either mismatch:
- s_payload_axis_tlast is 1 on a non-final beat;
- s_payload_axis_tlast is 0 on the final beat.
The output tlast SHALL always come from the counter.
REQ-025 SHALL, without CMD_GEN_TLAST_CHECK_EN, have no tlastError port and ignore s_payload_axis_tlast.

Structure
REQ-026 SHALL take the opcode values, OP_POS=28, OP_SIZE=4, OP_IMM_SIZE=28, FOG_LUT_BEATS=33 and the state encoding from the shared package cmd_stream_pkg, which the parser side also uses.
REQ-027 SHALL build the output register stage as the sub-module cmd_axis_skid_buffer, a 2-entry skid buffer, so that tready is registered with no throughput loss.

Verification
REQ-028 SHALL cover: FRAMEBUFFER request with imm=0x0000003 -> single beat 0x20000003 with tlast=1, then s_req_ready=1 again.
REQ-029 SHALL cover: RENDER_CONFIG request with imm=2 and payload 0xAABBCCDD -> beats 0x10000002 then 0xAABBCCDD, tlast on the second beat only.
REQ-030 SHALL cover: TRIANGLE_STREAM request with len=4 and m_cmd_axis_tready toggled randomly -> 5 beats in order, data stable while stalled, tlast on beat 5.
REQ-031 SHALL cover: FOG_LUT_STREAM request -> exactly 34 output beats; a 35th payload beat remains unconsumed.
REQ-032 SHALL cover: with CMD_GEN_TLAST_CHECK_EN, TEXTURE_STREAM len=8 and payload tlast asserted on beat 5 -> tlastError=1 from the next cycle, output tlast still on beat 8.
REQ-033 SHALL cover: resetn pulled low at payload beat 2 of a len=10 stream -> all outputs at reset values, and a following NOP emits 0x00000000 with tlast=1.

Source files
------------

// File: rtl/cmd_stream_pkg.sv
// ---------------------------------------------------------------------------
// cmd_stream_pkg : opcodes, header layout and FSM encoding shared with parser
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cmd_stream_pkg;

  localparam int OP_POS        = 28;
  localparam int OP_SIZE       = 4;
  localparam int OP_IMM_SIZE   = 28;
  localparam int FOG_LUT_BEATS = 33;
  localparam int LEN_W         = 14;

  typedef enum logic [OP_SIZE-1:0] {
    OP_NOP             = 4'd0,
    OP_RENDER_CONFIG   = 4'd1,
    OP_FRAMEBUFFER     = 4'd2,
    OP_TRIANGLE_STREAM = 4'd3,
    OP_TEXTURE_STREAM  = 4'd4,
    OP_FOG_LUT_STREAM  = 4'd5
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2
  } gen_state_t;

  // Unknown opcodes collapse to a bare NOP header.
  function automatic logic [31:0] header_word(input logic [OP_SIZE-1:0]     op,
                                              input logic [OP_IMM_SIZE-1:0] imm);
    logic [31:0] w;
    w = '0;
    if (op <= OP_FOG_LUT_STREAM) begin
      w[OP_POS +: OP_SIZE]   = op;
      w[OP_IMM_SIZE-1:0]     = imm;
    end
    return w;
  endfunction

  function automatic logic [LEN_W-1:0] payload_beats(input logic [OP_SIZE-1:0] op,
                                                     input logic [LEN_W-1:0]   len);
    case (op)
      OP_RENDER_CONFIG:   return LEN_W'(1);
      OP_FOG_LUT_STREAM:  return LEN_W'(FOG_LUT_BEATS);
      OP_TRIANGLE_STREAM,
      OP_TEXTURE_STREAM:  return len;
      default:            return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// cmd_axis_skid_buffer : 2-entry registered output stage; s_valid only when accepted
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmd_axis_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_last;
  logic             push;
  logic             out_free;

  assign empty    = !skid_valid;
  assign push     = s_valid && (!skid_valid || m_ready);
  assign out_free = !m_valid || m_ready;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        m_valid    <= 1'b1;
        m_data     <= skid_data;
        m_last     <= skid_last;
        skid_valid <= push;
        if (push) begin
          skid_data <= s_data;
          skid_last <= s_last;
        end
      end else begin
        m_valid <= push;
        if (push) begin
          m_data <= s_data;
          m_last <= s_last;
        end
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
      skid_last  <= s_last;
    end
  end

endmodule

`default_nettype wire

// File: rtl/command_stream_generator.sv
// ---------------------------------------------------------------------------
// command_stream_generator : header + payload command stream toward the parser
// Option macro CMD_GEN_TLAST_CHECK_EN adds the sticky tlastError output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module command_stream_generator
  import cmd_stream_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        s_req_valid,
  output logic                        s_req_ready,
  input  logic [3:0]                  s_req_op,
  input  logic [27:0]                 s_req_imm,
  input  logic [13:0]                 s_req_len,
  input  logic                        s_payload_axis_tvalid,
  output logic                        s_payload_axis_tready,
  input  logic                        s_payload_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_payload_axis_tdata,
  output logic                        m_cmd_axis_tvalid,
  input  logic                        m_cmd_axis_tready,
  output logic                        m_cmd_axis_tlast,
  output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
  output logic                        busy,
  output logic [2:0]                  dbgState
`ifdef CMD_GEN_TLAST_CHECK_EN
  ,
  output logic                        tlastError
`endif
);

  gen_state_t                  state, next_state;
  logic [LEN_W-1:0]            cnt, cnt_next;
  logic                        out_of_reset;
  logic                        req_fire;
  logic                        pl_fire;
  logic [LEN_W-1:0]            req_beats;
  logic                        sb_valid;
  logic [CMD_STREAM_WIDTH-1:0] sb_data;
  logic                        sb_last;
  logic                        sb_empty;

  assign req_beats   = payload_beats(s_req_op, s_req_len);
  assign s_req_ready = out_of_reset && (state == ST_IDLE) && sb_empty;
  assign req_fire    = s_req_valid && s_req_ready;
  assign pl_fire     = (state == ST_PAYLOAD) && s_payload_axis_tvalid && m_cmd_axis_tready;

  assign s_payload_axis_tready = (state == ST_PAYLOAD) && m_cmd_axis_tready;
  assign busy     = (state != ST_IDLE);
  assign dbgState = state;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      out_of_reset <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= cnt_next;
      out_of_reset <= 1'b1;
    end
  end

  // The header is pushed on the request handshake itself so it is valid one cycle later.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    sb_valid   = 1'b0;
    sb_data    = '0;
    sb_last    = 1'b0;
    case (state)
      ST_IDLE: begin
        sb_data[31:0] = header_word(s_req_op, s_req_imm);
        sb_last       = (req_beats == '0);
        if (req_fire) begin
          sb_valid   = 1'b1;
          cnt_next   = req_beats;
          next_state = ST_HEADER;
        end
      end
      ST_HEADER: begin
        next_state = (cnt == '0) ? ST_IDLE : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        sb_valid = pl_fire;
        sb_data  = s_payload_axis_tdata;
        sb_last  = (cnt == LEN_W'(1));
        if (pl_fire) begin
          cnt_next = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  cmd_axis_skid_buffer #(
    .WIDTH (CMD_STREAM_WIDTH)
  ) u_out_stage (
    .aclk    (aclk),
    .resetn  (resetn),
    .s_valid (sb_valid),
    .s_data  (sb_data),
    .s_last  (sb_last),
    .empty   (sb_empty),
    .m_valid (m_cmd_axis_tvalid),
    .m_ready (m_cmd_axis_tready),
    .m_data  (m_cmd_axis_tdata),
    .m_last  (m_cmd_axis_tlast)
  );

`ifdef CMD_GEN_TLAST_CHECK_EN
  logic tlast_err;
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      tlast_err <= 1'b0;
    end else if (pl_fire && (s_payload_axis_tlast != (cnt == LEN_W'(1)))) begin
      tlast_err <= 1'b1;
    end
  end
  assign tlastError = tlast_err;
`else
  logic unused_tlast;
  assign unused_tlast = s_payload_axis_tlast;
`endif

endmodule

`default_nettype wire

// File: tb/tb_command_stream_generator.sv
// ---------------------------------------------------------------------------
// tb_command_stream_generator : table-driven check of command_stream_generator
// ---------------------------------------------------------------------------
`default_nettype none

module tb_command_stream_generator;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [3:0]  s_req_op = '0;
  logic [27:0] s_req_imm = '0;
  logic [13:0] s_req_len = '0;
  logic        s_payload_axis_tvalid = 1'b0;
  logic        s_payload_axis_tready;
  logic        s_payload_axis_tlast = 1'b0;
  logic [31:0] s_payload_axis_tdata = '0;
  logic        m_cmd_axis_tvalid;
  logic        m_cmd_axis_tready = 1'b1;
  logic        m_cmd_axis_tlast;
  logic [31:0] m_cmd_axis_tdata;
  logic        busy;
  logic [2:0]  dbgState;
`ifdef CMD_GEN_TLAST_CHECK_EN
  logic        tlastError;
`endif

  always #5 aclk = ~aclk;

  command_stream_generator #(.CMD_STREAM_WIDTH(32)) dut (
    .aclk                  (aclk),
    .resetn                (resetn),
    .s_req_valid           (s_req_valid),
    .s_req_ready           (s_req_ready),
    .s_req_op              (s_req_op),
    .s_req_imm             (s_req_imm),
    .s_req_len             (s_req_len),
    .s_payload_axis_tvalid (s_payload_axis_tvalid),
    .s_payload_axis_tready (s_payload_axis_tready),
    .s_payload_axis_tlast  (s_payload_axis_tlast),
    .s_payload_axis_tdata  (s_payload_axis_tdata),
    .m_cmd_axis_tvalid     (m_cmd_axis_tvalid),
    .m_cmd_axis_tready     (m_cmd_axis_tready),
    .m_cmd_axis_tlast      (m_cmd_axis_tlast),
    .m_cmd_axis_tdata      (m_cmd_axis_tdata),
    .busy                  (busy),
    .dbgState              (dbgState)
`ifdef CMD_GEN_TLAST_CHECK_EN
    ,
    .tlastError            (tlastError)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [27:0] imm;
    logic [13:0] len;
    logic [31:0] exp_hdr;
    int          exp_n;
    logic [31:0] base;
    bit          rnd;
    int          extra;
  } vec_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  vec_t  vecs[12];
  beat_t pl_q[$];
  beat_t out_q[$];
  time   out_t[$];
  int    total = 0;
  int    bad = 0;
  bit    rnd_mode = 1'b0;
  bit    pl_fire = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t stall_beat;
  int    tl_bad = -1;
  int    pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload source, output monitor and downstream ready generator.
  always begin
    @(negedge aclk);
    pl_fire = s_payload_axis_tvalid && s_payload_axis_tready;
    if (stall_prev) begin
      check("hold_valid", 64'(m_cmd_axis_tvalid), 64'd1);
      check("hold_beat", 64'({m_cmd_axis_tlast, m_cmd_axis_tdata}), 64'(stall_beat));
    end
    if (m_cmd_axis_tvalid && m_cmd_axis_tready) begin
      out_q.push_back({m_cmd_axis_tlast, m_cmd_axis_tdata});
      out_t.push_back($time);
    end
    stall_prev = m_cmd_axis_tvalid && !m_cmd_axis_tready;
    stall_beat = {m_cmd_axis_tlast, m_cmd_axis_tdata};
    @(posedge aclk);
    #1;
    if (pl_fire && pl_q.size() > 0) begin
      void'(pl_q.pop_front());
      pops++;
`ifdef CMD_GEN_TLAST_CHECK_EN
      if (tl_bad >= 0) check("tlast_err_timing", 64'(tlastError), 64'(pops > tl_bad));
`endif
    end
    s_payload_axis_tvalid = (pl_q.size() > 0);
    s_payload_axis_tdata  = (pl_q.size() > 0) ? pl_q[0].data : 32'd0;
    s_payload_axis_tlast  = (pl_q.size() > 0) ? pl_q[0].last : 1'b0;
    m_cmd_axis_tready     = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic run_cmd(input vec_t v, input int bad_idx);
    int    n;
    int    cyc;
    beat_t exp_b;
    n = v.exp_n;
    out_q.delete();
    out_t.delete();
    pops = 0;
    for (int i = 0; i < n + v.extra; i++) begin
      exp_b.last = (bad_idx >= 0) ? (i == bad_idx) : (i == n - 1);
      exp_b.data = v.base + 32'(i);
      pl_q.push_back(exp_b);
    end
    rnd_mode = v.rnd;
    cyc = 0;
    while (!s_req_ready && cyc < 100) begin
      @(posedge aclk); #2; cyc++;
    end
    check("req_ready_idle", 64'(s_req_ready), 64'd1);
    s_req_valid = 1'b1;
    s_req_op    = v.op;
    s_req_imm   = v.imm;
    s_req_len   = v.len;
    @(posedge aclk); #2;
    s_req_valid = 1'b0;
    check("hdr_latency_valid", 64'(m_cmd_axis_tvalid), 64'd1);
    check("hdr_latency_data", 64'(m_cmd_axis_tdata), 64'(v.exp_hdr));
    check("busy_header", 64'(busy), 64'd1);
    check("state_header", 64'(dbgState), 64'd1);
    cyc = 0;
    while (out_q.size() < n + 1 && cyc < 400) begin
      @(posedge aclk); #2; cyc++;
    end
    repeat (3) @(posedge aclk);
    #2;
    check("beat_count", 64'(out_q.size()), 64'(n + 1));
    for (int i = 0; i < out_q.size() && i <= n; i++) begin
      if (i == 0) exp_b = {(n == 0), v.exp_hdr};
      else        exp_b = {(i == n), v.base + 32'(i - 1)};
      check("beat", 64'(out_q[i]), 64'(exp_b));
    end
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_req_ready", 64'(s_req_ready), 64'd1);
    check("payload_left", 64'(pl_q.size()), 64'(v.extra));
    check("pl_tready_idle", 64'(s_payload_axis_tready), 64'd0);
    if (!v.rnd && n > 1 && out_q.size() == n + 1)
      check("throughput", 64'(out_t[n] - out_t[1]), 64'((n - 1) * 10));
    pl_q.delete();
    rnd_mode = 1'b0;
  endtask

  initial begin
    vec_t rv;
    //            op     imm           len     hdr           n   base          rnd extra
    vecs[0]  = '{4'd2,  28'h0000003, 14'd0,   32'h2000_0003, 0,  32'h0,        0, 0};
    vecs[1]  = '{4'd1,  28'h0000002, 14'd0,   32'h1000_0002, 1,  32'hAABB_CCDD, 0, 0};
    vecs[2]  = '{4'd3,  28'h0000055, 14'd4,   32'h3000_0055, 4,  32'h1111_0000, 1, 0};
    vecs[3]  = '{4'd5,  28'h0000007, 14'd100, 32'h5000_0007, 33, 32'h5A00_0000, 0, 1};
    vecs[4]  = '{4'd0,  28'h0000123, 14'd0,   32'h0000_0123, 0,  32'h0,        0, 0};
    vecs[5]  = '{4'd9,  28'hFFFFFFF, 14'd7,   32'h0000_0000, 0,  32'h0,        0, 0};
    vecs[6]  = '{4'd4,  28'h0ABCDEF, 14'd0,   32'h40AB_CDEF, 0,  32'h0,        0, 0};
    vecs[7]  = '{4'd4,  28'h0000001, 14'd3,   32'h4000_0001, 3,  32'h2222_0000, 0, 0};
    vecs[8]  = '{4'd2,  28'hFFFFFFF, 14'd5,   32'h2FFF_FFFF, 0,  32'h0,        0, 0};
    vecs[9]  = '{4'd15, 28'h0000001, 14'd9,   32'h0000_0000, 0,  32'h0,        0, 0};
    vecs[10] = '{4'd3,  28'h0FFFFFF, 14'd6,   32'h30FF_FFFF, 6,  32'h3333_0000, 1, 0};
    vecs[11] = '{4'd1,  28'hFFFFFFF, 14'd0,   32'h1FFF_FFFF, 1,  32'h0BAD_F00D, 0, 0};

    repeat (3) @(posedge aclk);
    #2;
    check("rst_req_ready", 64'(s_req_ready), 64'd0);
    check("rst_tvalid", 64'(m_cmd_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_cmd_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_cmd_axis_tdata), 64'd0);
    check("rst_pl_tready", 64'(s_payload_axis_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbgState), 64'd0);
    resetn = 1'b1;
    @(posedge aclk); #2;
    check("ready_after_reset", 64'(s_req_ready), 64'd1);

    for (int k = 0; k < 12; k++) run_cmd(vecs[k], -1);

    // Reset in the middle of a len=10 triangle stream.
    out_q.delete();
    for (int i = 0; i < 10; i++) pl_q.push_back({(i == 9), 32'h7700_0000 + 32'(i)});
    s_req_valid = 1'b1;
    s_req_op    = 4'd3;
    s_req_imm   = 28'h00000AA;
    s_req_len   = 14'd10;
    @(posedge aclk); #2;
    s_req_valid = 1'b0;
    for (int cyc = 0; cyc < 50 && out_q.size() < 2; cyc++) begin
      @(posedge aclk); #2;
    end
    check("mid_beats_seen", 64'(out_q.size()), 64'd2);
    resetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(m_cmd_axis_tvalid), 64'd0);
    check("mid_rst_tlast", 64'(m_cmd_axis_tlast), 64'd0);
    check("mid_rst_tdata", 64'(m_cmd_axis_tdata), 64'd0);
    check("mid_rst_req_ready", 64'(s_req_ready), 64'd0);
    check("mid_rst_pl_tready", 64'(s_payload_axis_tready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_state", 64'(dbgState), 64'd0);
    for (int i = 0; i < out_q.size(); i++) check("no_partial_tlast", 64'(out_q[i].last), 64'd0);
    pl_q.delete();
    repeat (2) @(posedge aclk);
    #2;
    resetn = 1'b1;
    @(posedge aclk); #2;
    check("ready_after_mid_reset", 64'(s_req_ready), 64'd1);
    rv = '{4'd0, 28'h0, 14'd0, 32'h0, 0, 32'h0, 0, 0};
    run_cmd(rv, -1);

`ifdef CMD_GEN_TLAST_CHECK_EN
    check("tlast_err_clear", 64'(tlastError), 64'd0);
    tl_bad = 4;
    rv = '{4'd4, 28'h0000008, 14'd8, 32'h4000_0008, 8, 32'h4444_0000, 0, 0};
    run_cmd(rv, 4);
    tl_bad = -1;
    check("tlast_err_sticky", 64'(tlastError), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
